like_alu: RTL and testbench

LIKE_ALU -- requirements
Module: like_alu

---
 rtl/like_alu_if.sv | 22 ++
 rtl/like_alu.sv | 62 ++++++
 tb/tb_like_alu.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/like_alu_if.sv
// Operand/result bundle for like_alu: the master drives operands and the select code,
// and the slave returns the registered result.
interface like_alu_if;
  logic [4:0] Inp_A;
  logic [4:0] Inp_B;
  logic [1:0] select;
  logic [4:0] out;

  modport master (
    output Inp_A,
    output Inp_B,
    output select,
    input  out
  );

  modport slave (
    input  Inp_A,
    input  Inp_B,
    input  select,
    output out
  );
endinterface

// File: rtl/like_alu.sv
// 5-bit ALU (ADD/SUB/XOR/SLTU) with a single registered result and one-cycle latency.
// ADD, SUB and SLTU share one ripple-carry adder built from full-adder cells.
module like_alu (
  input  logic        clk,
  input  logic        rst,
  like_alu_if.slave   bus
);

  localparam int W = 5;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_XOR  = 2'b10,
    OP_SLTU = 2'b11
  } op_e;

  op_e          op;
  logic         sub_mode;
  logic [W-1:0] b_eff;
  logic [W:0]   carry;
  logic [W-1:0] sum;
  logic [W-1:0] out_d;
  logic [W-1:0] out_q;

  assign op = op_e'(bus.select);

  // SUB and SLTU both encode select[0]=1; they invert B and force carry-in high.
  assign sub_mode = bus.select[0];
  assign b_eff    = bus.Inp_B ^ {W{sub_mode}};
  assign carry[0] = sub_mode;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]     = bus.Inp_A[i] ^ b_eff[i] ^ carry[i];
    assign carry[i+1] = (bus.Inp_A[i] & b_eff[i]) | (carry[i] & (bus.Inp_A[i] ^ b_eff[i]));
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    out_d = '0;
    unique case (op)
      OP_ADD:  out_d = sum;
      OP_SUB:  out_d = sum;
      OP_XOR:  out_d = bus.Inp_A ^ bus.Inp_B;
      // No carry-out from A + ~B + 1 means the subtraction borrowed, i.e. A < B.
      OP_SLTU: out_d = {{(W-1){1'b0}}, ~carry[W]};
      default: out_d = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_like_alu.sv
// Directed self-checking bench for like_alu: vector tables, reset, latency and an
// exhaustive sweep against a behavioural reference.
`timescale 1ns/1ps
module tb_like_alu;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  like_alu_if bus ();

  like_alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    logic [1:0] sel;
    logic [4:0] exp;
  } vec_t;

  function automatic logic [4:0] ref_alu(input logic [4:0] a, input logic [4:0] b,
                                         input logic [1:0] sel);
    int ai, bi;
    ai = int'(a);
    bi = int'(b);
    case (sel)
      2'b00:   return 5'((ai + bi) % 32);
      2'b01:   return 5'((ai - bi + 32) % 32);
      2'b10:   return a ^ b;
      default: return (ai < bi) ? 5'd1 : 5'd0;
    endcase
  endfunction

  // Drive operands on the falling edge, then step past the next rising edge.
  task automatic apply(input logic [4:0] a, input logic [4:0] b, input logic [1:0] sel);
    @(negedge clk);
    bus.Inp_A  = a;
    bus.Inp_B  = b;
    bus.select = sel;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    bus.Inp_A  = 5'b10101;
    bus.Inp_B  = 5'b00011;
    bus.select = 2'b00;
    #1;
    total_cnt++;
    if (bus.out !== 5'b00000)
      $display("FAIL reset_async: out=%b expected=%b", bus.out, 5'b00000);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.out !== 5'b00000)
      $display("FAIL reset_hold_initial: out=%b expected=%b", bus.out, 5'b00000);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_vectors;
    vec_t v[22];
    v[0]  = '{5'b01100, 5'b10001, 2'b00, 5'b11101};
    v[1]  = '{5'b01100, 5'b10001, 2'b01, 5'b11011};
    v[2]  = '{5'b01100, 5'b10001, 2'b10, 5'b11101};
    v[3]  = '{5'b01100, 5'b10001, 2'b11, 5'b00001};
    v[4]  = '{5'b11111, 5'b00001, 2'b00, 5'b00000};
    v[5]  = '{5'b11111, 5'b00001, 2'b01, 5'b11110};
    v[6]  = '{5'b11111, 5'b00001, 2'b10, 5'b11110};
    v[7]  = '{5'b11111, 5'b00001, 2'b11, 5'b00000};
    v[8]  = '{5'b11010, 5'b01111, 2'b00, 5'b01001};
    v[9]  = '{5'b11010, 5'b01111, 2'b01, 5'b01011};
    v[10] = '{5'b11010, 5'b01111, 2'b10, 5'b10101};
    v[11] = '{5'b11010, 5'b01111, 2'b11, 5'b00000};
    v[12] = '{5'b11111, 5'b00000, 2'b00, 5'b11111};
    v[13] = '{5'b11111, 5'b00000, 2'b01, 5'b11111};
    v[14] = '{5'b11111, 5'b00000, 2'b10, 5'b11111};
    v[15] = '{5'b11111, 5'b00000, 2'b11, 5'b00000};
    v[16] = '{5'b10101, 5'b01100, 2'b00, 5'b00001};
    v[17] = '{5'b10101, 5'b01100, 2'b01, 5'b01001};
    v[18] = '{5'b10101, 5'b01100, 2'b10, 5'b11001};
    v[19] = '{5'b10101, 5'b01100, 2'b11, 5'b00000};
    v[20] = '{5'b00111, 5'b00111, 2'b01, 5'b00000};
    v[21] = '{5'b00111, 5'b00111, 2'b11, 5'b00000};
    for (int i = 0; i < 22; i++) begin
      apply(v[i].a, v[i].b, v[i].sel);
      total_cnt++;
      if (bus.out !== v[i].exp)
        $display("FAIL vector_%0d a=%b b=%b sel=%b: out=%b expected=%b",
                 i, v[i].a, v[i].b, v[i].sel, bus.out, v[i].exp);
      else pass_cnt++;
    end
    // Equal operands under XOR must also clear.
    apply(5'b10110, 5'b10110, 2'b10);
    total_cnt++;
    if (bus.out !== 5'b00000)
      $display("FAIL equal_xor: out=%b expected=%b", bus.out, 5'b00000);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset;
    apply(5'b01100, 5'b10001, 2'b00);
    total_cnt++;
    if (bus.out !== 5'b11101)
      $display("FAIL mid_reset_preload: out=%b expected=%b", bus.out, 5'b11101);
    else pass_cnt++;
    @(negedge clk);
    bus.Inp_A  = 5'b00011;
    bus.Inp_B  = 5'b00100;
    bus.select = 2'b00;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (bus.out !== 5'b00000)
      $display("FAIL mid_reset_async: out=%b expected=%b", bus.out, 5'b00000);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      bus.Inp_A = 5'(bus.Inp_A + 5'd3);
      total_cnt++;
      if (bus.out !== 5'b00000)
        $display("FAIL mid_reset_hold_%0d: out=%b expected=%b", k, bus.out, 5'b00000);
      else pass_cnt++;
    end
    @(negedge clk);
    rst        = 1'b0;
    bus.Inp_A  = 5'b11010;
    bus.Inp_B  = 5'b01111;
    bus.select = 2'b10;
    #1;
    total_cnt++;
    if (bus.out !== 5'b00000)
      $display("FAIL release_before_edge: out=%b expected=%b", bus.out, 5'b00000);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (bus.out !== 5'b10101)
      $display("FAIL release_first_edge: out=%b expected=%b", bus.out, 5'b10101);
    else pass_cnt++;
  endtask

  task automatic test_latency;
    apply(5'b00101, 5'b00011, 2'b00);
    total_cnt++;
    if (bus.out !== 5'b01000)
      $display("FAIL latency_first: out=%b expected=%b", bus.out, 5'b01000);
    else pass_cnt++;
    @(negedge clk);
    bus.Inp_A  = 5'b11000;
    bus.Inp_B  = 5'b00110;
    bus.select = 2'b01;
    #2;
    bus.select = 2'b10;
    #1;
    total_cnt++;
    if (bus.out !== 5'b01000)
      $display("FAIL latency_hold: out=%b expected=%b", bus.out, 5'b01000);
    else pass_cnt++;
    @(posedge clk);
    #1;
    total_cnt++;
    if (bus.out !== 5'b11110)
      $display("FAIL latency_update: out=%b expected=%b", bus.out, 5'b11110);
    else pass_cnt++;
  endtask

  task automatic test_exhaustive;
    int errs;
    logic [4:0] exp;
    errs = 0;
    for (int s = 0; s < 4; s++) begin
      for (int a = 0; a < 32; a++) begin
        for (int b = 0; b < 32; b++) begin
          apply(5'(a), 5'(b), 2'(s));
          exp = ref_alu(5'(a), 5'(b), 2'(s));
          total_cnt++;
          if (bus.out !== exp) begin
            errs++;
            if (errs <= 10)
              $display("FAIL exhaustive a=%0d b=%0d sel=%0d: out=%b expected=%b",
                       a, b, s, bus.out, exp);
          end else pass_cnt++;
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [4:0] a_q[8];
    logic [4:0] b_q[8];
    logic [1:0] s_q[8];
    logic [4:0] exp;
    for (int i = 0; i < 8; i++) begin
      a_q[i] = 5'($urandom_range(0, 31));
      b_q[i] = 5'($urandom_range(0, 31));
      s_q[i] = 2'($urandom_range(0, 3));
    end
    for (int i = 0; i < 8; i++) begin
      apply(a_q[i], b_q[i], s_q[i]);
      exp = ref_alu(a_q[i], b_q[i], s_q[i]);
      total_cnt++;
      if (bus.out !== exp)
        $display("FAIL back_to_back_%0d: out=%b expected=%b", i, bus.out, exp);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_vectors();
    test_mid_reset();
    test_latency();
    test_back_to_back();
    test_exhaustive();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
